// File: rtl/pts_serializer.sv
// rtl/pts_serializer.sv - parallel-to-serial converter with valid/ready word input and bit strobe
module pts_serializer #(
    parameter int DATA_W     = 32,
    parameter bit LSB_FIRST  = 1'b0,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              bit_en,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              frame_start,
    output logic              done,
    output logic              busy
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] shift_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              done_q;
    logic              last_bit;
    logic              accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        ser_valid   = 1'b0;
        ser_out     = IDLE_LEVEL;
        frame_start = 1'b0;
        last_bit    = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy        = 1'b1;
                ser_valid   = 1'b1;
                ser_out     = LSB_FIRST ? shift_q[0] : shift_q[DATA_W-1];
                frame_start = (cnt_q == '0);
                // Last-bit cycle reopens the input so the next word follows with no gap
                if (bit_en && (cnt_q == LAST_CNT)) begin
                    last_bit = 1'b1;
                    in_ready = 1'b1;
                    if (!in_valid) begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign done   = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= last_bit;
            if (accept) begin
                shift_q <= in_data;
                cnt_q   <= '0;
            end else if ((state == S_SHIFT) && bit_en) begin
                if (last_bit) begin
                    cnt_q <= '0;
                end else begin
                    shift_q <= LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
                    cnt_q   <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pts_serializer.sv
// tb/tb_pts_serializer.sv - directed self-checking bench for pts_serializer
module tb_pts_serializer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic        a_valid = 1'b0, a_en = 1'b0;
    logic [31:0] a_data = '0;
    logic        a_ready, a_ser, a_sv, a_fs, a_done, a_busy;

    logic        b_valid = 1'b0, b_en = 1'b0;
    logic [7:0]  b_data = '0;
    logic        b_ready, b_ser, b_sv, b_fs, b_done, b_busy;

    logic        c_valid = 1'b0, c_en = 1'b0;
    logic [7:0]  c_data = '0;
    logic        c_ready, c_ser, c_sv, c_fs, c_done, c_busy;

    pts_serializer #(.DATA_W(32), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
        .bit_en(a_en), .ser_out(a_ser), .ser_valid(a_sv), .frame_start(a_fs), .done(a_done), .busy(a_busy));

    pts_serializer #(.DATA_W(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
        .bit_en(b_en), .ser_out(b_ser), .ser_valid(b_sv), .frame_start(b_fs), .done(b_done), .busy(b_busy));

    pts_serializer #(.DATA_W(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_valid), .in_ready(c_ready), .in_data(c_data),
        .bit_en(c_en), .ser_out(c_ser), .ser_valid(c_sv), .frame_start(c_fs), .done(c_done), .busy(c_busy));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One isolated 32-bit word on dut_a with bit_en tied high
    task automatic a_word(input logic [31:0] d, input string tag);
        logic [31:0] w;
        int fs_err, done_err, sv_err;
        w = '0; fs_err = 0; done_err = 0; sv_err = 0;
        @(negedge clk);
        a_valid = 1'b1; a_data = d; a_en = 1'b1;
        #1 check({tag, "_ready_idle"}, a_ready, 1);
        for (int k = 0; k <= 32; k++) begin
            @(negedge clk);
            a_valid = 1'b0; a_data = 32'h5A5A_5A5A;
            #1;
            if (k < 32) begin
                w[31-k] = a_ser;
                if (a_fs !== (k == 0)) fs_err++;
                if (a_sv !== 1'b1 || a_busy !== 1'b1) sv_err++;
            end
            if (a_done !== (k == 32)) done_err++;
        end
        check({tag, "_word"}, w, d);
        check({tag, "_fs_err"}, fs_err, 0);
        check({tag, "_sv_err"}, sv_err, 0);
        check({tag, "_done_err"}, done_err, 0);
        check({tag, "_idle"}, {a_ser, a_sv, a_busy}, 3'b000);
        @(negedge clk);
        #1 check({tag, "_done_clr"}, a_done, 0);
    endtask

    initial begin
        logic [31:0] w1, w2;
        logic [7:0]  wb;
        int e_ser, e_fs, e_rdy, e_done;

        #1;
        check("rst_a", {a_ser, a_sv, a_fs, a_done, a_busy, a_ready}, 6'b000001);
        check("rst_b", {b_ser, b_sv, b_fs, b_done, b_busy, b_ready}, 6'b100001);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // MSB-first 32-bit word
        a_word(32'hA5C3_0F81, "msb");

        // LSB-first 8-bit word, idle level high
        @(negedge clk);
        b_valid = 1'b1; b_data = 8'h01; b_en = 1'b1;
        wb = '0; e_fs = 0; e_done = 0;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            b_valid = 1'b0;
            #1;
            if (k < 8) wb[k] = b_ser;
            if (k < 8 && b_fs !== (k == 0)) e_fs++;
            if (b_done !== (k == 8)) e_done++;
        end
        check("lsb_word", wb, 8'h01);
        check("lsb_fs_err", e_fs, 0);
        check("lsb_done_err", e_done, 0);
        check("lsb_idle", {b_ser, b_sv, b_busy}, 3'b100);

        // bit_en every third cycle: each bit held three cycles
        @(negedge clk);
        c_valid = 1'b1; c_data = 8'hF0; c_en = 1'b0;
        #1 check("slow_ready", c_ready, 1);
        e_ser = 0; e_done = 0; e_rdy = 0;
        for (int k = 0; k <= 24; k++) begin
            @(negedge clk);
            c_valid = 1'b0; c_data = 8'h0F;
            c_en = (k % 3 == 2);
            #1;
            if (k < 24 && (c_ser !== c_data_bit(k / 3) || c_sv !== 1'b1)) e_ser++;
            if (c_done !== (k == 24)) e_done++;
            if (k < 24 && c_ready !== (k == 23)) e_rdy++;
        end
        c_en = 1'b0;
        check("slow_ser_err", e_ser, 0);
        check("slow_done_err", e_done, 0);
        check("slow_ready_err", e_rdy, 0);
        check("slow_idle", {c_ser, c_sv, c_busy}, 3'b000);

        // Back-to-back words with in_valid held high
        @(negedge clk);
        a_valid = 1'b1; a_data = 32'hFFFF_FFFF; a_en = 1'b1;
        e_ser = 0; e_fs = 0; e_rdy = 0; e_done = 0;
        for (int k = 0; k <= 64; k++) begin
            @(negedge clk);
            if (k == 0) a_data = 32'h0000_0000;
            if (k == 32) a_valid = 1'b0;
            #1;
            if (k < 64 && a_ser !== (k < 32)) e_ser++;
            if (a_fs !== (k == 0 || k == 32)) e_fs++;
            if (a_ready !== (k == 31 || k >= 63)) e_rdy++;
            if (a_done !== (k == 32 || k == 64)) e_done++;
        end
        check("b2b_ser_err", e_ser, 0);
        check("b2b_fs_err", e_fs, 0);
        check("b2b_ready_err", e_rdy, 0);
        check("b2b_done_err", e_done, 0);
        check("b2b_idle", {a_ser, a_busy}, 2'b00);

        // Reset at bit 10 aborts the word
        @(negedge clk);
        a_valid = 1'b1; a_data = 32'h1234_5678;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            a_valid = 1'b0;
        end
        @(negedge clk);
        #1 check("pre_rst_busy", a_busy, 1);
        rst_n = 1'b0;
        #1 check("mid_rst", {a_ser, a_sv, a_busy, a_done, a_ready}, 5'b00001);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1 check("post_rst_nodone", {a_done, a_busy}, 2'b00);
        a_word(32'h8000_0001, "after_rst");

        // in_valid mid-word is held off until the last-bit cycle
        @(negedge clk);
        a_valid = 1'b1; a_data = 32'hDEAD_BEEF;
        w1 = '0; w2 = '0; e_rdy = 0; e_done = 0; e_fs = 0;
        for (int k = 0; k <= 64; k++) begin
            @(negedge clk);
            if (k == 0) a_valid = 1'b0;
            if (k == 5) begin a_valid = 1'b1; a_data = 32'h1111_1111; end
            if (k == 10) a_data = 32'h0F0F_0F0F;
            if (k == 32) a_valid = 1'b0;
            #1;
            if (k < 32) w1[31-k] = a_ser;
            else if (k < 64) w2[63-k] = a_ser;
            if (a_ready !== (k == 31 || k >= 63)) e_rdy++;
            if (a_done !== (k == 32 || k == 64)) e_done++;
            if (a_fs !== (k == 0 || k == 32)) e_fs++;
        end
        check("hold_word1", w1, 32'hDEAD_BEEF);
        check("hold_word2", w2, 32'h0F0F_0F0F);
        check("hold_ready_err", e_rdy, 0);
        check("hold_done_err", e_done, 0);
        check("hold_fs_err", e_fs, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic logic c_data_bit(input int i);
        logic [7:0] v;
        v = 8'hF0;
        return v[7-i];
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
